// File: rtl/down_sample_sched_pkg.sv
// Shared types for the down-sample schedule controller.
package down_sample_sched_pkg;
  localparam int CTRL_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

  // Loop-index vector handed to a buffer port; element [0] is always zero.
  typedef logic [CTRL_W-1:0] ctrl_vars_t [4];

  // Pool window index carried through the delay lines.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [CTRL_W-1:0] i;
    logic [CTRL_W-1:0] j;
  } pool_idx_t;
endpackage

// File: rtl/down_sample_sched_delay.sv
// Fixed-depth shift line of {valid, pool_idx_t}; depth 0 is a wire.
// The whole line freezes under stall and the output strobe is suppressed
// for that cycle, so a stalled cycle delays the event instead of repeating it.
module down_sample_sched_delay
  import down_sample_sched_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      stall,
  input  logic      in_vld,
  input  pool_idx_t in_idx,
  output logic      out_vld,
  output pool_idx_t out_idx,
  output logic      pend
);
  logic [DEPTH:0] vld_pipe;
  pool_idx_t      idx_pipe [DEPTH+1];

  assign vld_pipe[0] = in_vld;
  assign idx_pipe[0] = in_idx;

  generate
    if (DEPTH > 0) begin : g_line
      logic [DEPTH:1] vld_q;
      pool_idx_t      idx_q [1:DEPTH];

      // Advance one stage per non-stalled cycle; flush empties the line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 1; i <= DEPTH; i++) idx_q[i] <= '0;
        end else if (flush) begin
          vld_q <= '0;
          for (int i = 1; i <= DEPTH; i++) idx_q[i] <= '0;
        end else if (!stall) begin
          vld_q <= vld_pipe[DEPTH-1:0];
          for (int i = 1; i <= DEPTH; i++) idx_q[i] <= idx_pipe[i-1];
        end
      end

      assign vld_pipe[DEPTH:1] = vld_q;
      for (genvar g = 1; g <= DEPTH; g++) begin : g_idx
        assign idx_pipe[g] = idx_q[g];
      end
    end
  endgenerate

  // Entries that will still be inside the line after the next shift.
  always_comb begin
    pend = 1'b0;
    for (int i = 1; i < DEPTH; i++) pend = pend | vld_pipe[i];
  end

  assign out_vld = vld_pipe[DEPTH] & ~stall;
  assign out_idx = idx_pipe[DEPTH];
endmodule

// File: rtl/down_sample_schedule_ctrl.sv
// Static schedule for the 2x2 average-pool pipeline: raster input writes,
// pool reads once each window completes, pool-result writes after compute.
module down_sample_schedule_ctrl
  import down_sample_sched_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int CH          = 4,
  parameter int POOL_LAT    = 1,
  parameter int COMPUTE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       start,
  input  logic       stall,
  output logic       in_wen,
  output ctrl_vars_t in_ctrl_vars,
  output logic       pool_ren,
  output ctrl_vars_t pool_ctrl_vars,
  output logic       pool_wen,
  output ctrl_vars_t pool_wr_ctrl_vars,
  output logic       out_ren,
  output logic       busy,
  output logic       done
);
  sched_state_t      state;
  logic [CTRL_W-1:0] c_q, y_q, x_q;
  logic              x_last, y_last, c_last;
  logic              issue, win;
  pool_idx_t         win_idx, rd_idx, wr_idx;
  logic              rd_vld, wr_vld, pend_rd, pend_wr;

  assign x_last = (x_q == CTRL_W'(IMG_W - 1));
  assign y_last = (y_q == CTRL_W'(IMG_H - 1));
  assign c_last = (c_q == CTRL_W'(CH - 1));

  // One input write per non-stalled RUN cycle, at the current raster indices.
  assign issue   = (state == RUN) && !stall;
  assign win     = issue && y_q[0] && x_q[0];
  assign win_idx = '{c: c_q, i: {1'b0, y_q[CTRL_W-1:1]}, j: {1'b0, x_q[CTRL_W-1:1]}};

  // Control FSM and raster counters; flush beats everything, stall freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c_q   <= '0;
      y_q   <= '0;
      x_q   <= '0;
    end else if (flush) begin
      state <= IDLE;
      c_q   <= '0;
      y_q   <= '0;
      x_q   <= '0;
    end else if (!stall) begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= RUN;
          c_q   <= '0;
          y_q   <= '0;
          x_q   <= '0;
        end
        RUN: begin
          if (x_last) begin
            x_q <= '0;
            if (y_last) begin
              y_q <= '0;
              c_q <= c_last ? '0 : c_q + 1'b1;
            end else begin
              y_q <= y_q + 1'b1;
            end
          end else begin
            x_q <= x_q + 1'b1;
          end
          if (x_last && y_last && c_last) state <= DRAIN;
        end
        // Done once nothing would remain in either line after this edge.
        DRAIN: if (!pend_rd && !rd_vld && !pend_wr) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  down_sample_sched_delay #(.DEPTH(POOL_LAT)) u_rd_line (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_vld(win), .in_idx(win_idx),
    .out_vld(rd_vld), .out_idx(rd_idx), .pend(pend_rd)
  );

  down_sample_sched_delay #(.DEPTH(COMPUTE_LAT)) u_wr_line (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_vld(rd_vld), .in_idx(rd_idx),
    .out_vld(wr_vld), .out_idx(wr_idx), .pend(pend_wr)
  );

  assign in_wen   = issue;
  assign pool_ren = rd_vld;
  assign pool_wen = wr_vld;
  assign out_ren  = wr_vld;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Index vectors read zero whenever their strobe is low.
  always_comb begin
    in_ctrl_vars[0]      = '0;
    in_ctrl_vars[1]      = issue ? c_q : '0;
    in_ctrl_vars[2]      = issue ? y_q : '0;
    in_ctrl_vars[3]      = issue ? x_q : '0;
    pool_ctrl_vars[0]    = '0;
    pool_ctrl_vars[1]    = rd_vld ? rd_idx.c : '0;
    pool_ctrl_vars[2]    = rd_vld ? rd_idx.i : '0;
    pool_ctrl_vars[3]    = rd_vld ? rd_idx.j : '0;
    pool_wr_ctrl_vars[0] = '0;
    pool_wr_ctrl_vars[1] = wr_vld ? wr_idx.c : '0;
    pool_wr_ctrl_vars[2] = wr_vld ? wr_idx.i : '0;
    pool_wr_ctrl_vars[3] = wr_vld ? wr_idx.j : '0;
  end
endmodule

// File: tb/tb_down_sample_schedule_ctrl.sv
// Scoreboard bench: expected strobe events (cycle + index vector) are queued
// when a frame is started and consumed as the DUT raises each strobe.
module tb_down_sample_schedule_ctrl;
  import down_sample_sched_pkg::*;

  localparam int W = 4, H = 4, C = 2, PL = 1, CL = 2;
  localparam int BIG = 1000000;

  logic clk, rst_n, flush, start, stall;
  logic in_wen, pool_ren, pool_wen, out_ren, busy, done;
  ctrl_vars_t in_cv, rd_cv, wr_cv;

  typedef struct { int t; logic [63:0] v; } ev_t;
  ev_t q [3][$];
  string nm [3] = '{"in", "rd", "wr"};

  int checks = 0, errors = 0;
  int cyc = 0, s0 = 0, exp_done = 0;

  down_sample_schedule_ctrl #(
    .IMG_W(W), .IMG_H(H), .CH(C), .POOL_LAT(PL), .COMPUTE_LAT(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .stall(stall),
    .in_wen(in_wen), .in_ctrl_vars(in_cv),
    .pool_ren(pool_ren), .pool_ctrl_vars(rd_cv),
    .pool_wen(pool_wen), .pool_wr_ctrl_vars(wr_cv),
    .out_ren(out_ren), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input ctrl_vars_t v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic int sh(input int t, input int st_at, input int st_len);
    return (t >= st_at) ? t + st_len : t;
  endfunction

  // Expected trace of a frame started in cycle s: write k at s+1+k; window
  // write at t gives read at t+PL and result write at t+PL+CL; events at or
  // after the stall start move by the stall length; events after cut dropped.
  task automatic push_frame(input int s, input int st_at, input int st_len, input int cut);
    int k = 0;
    for (int c = 0; c < C; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          int t0 = s + 1 + k;
          int t  = sh(t0, st_at, st_len);
          k++;
          if (t <= cut) q[0].push_back('{t, {16'd0, 16'(c), 16'(y), 16'(x)}});
          if ((y % 2 == 1) && (x % 2 == 1)) begin
            int tr = sh(t0 + PL, st_at, st_len);
            int tw = sh(t0 + PL + CL, st_at, st_len);
            if (tr <= cut) q[1].push_back('{tr, {16'd0, 16'(c), 16'(y / 2), 16'(x / 2)}});
            if (tw <= cut) q[2].push_back('{tw, {16'd0, 16'(c), 16'(y / 2), 16'(x / 2)}});
            exp_done = tw + 1;
          end
        end
  endtask

  // Monitor: every strobe must match the head of its queue in cycle and vars.
  always @(negedge clk) begin
    logic [2:0]  stb;
    logic [63:0] vv [3];
    ev_t         e;
    stb   = {pool_wen, pool_ren, in_wen};
    vv[0] = pk(in_cv);
    vv[1] = pk(rd_cv);
    vv[2] = pk(wr_cv);
    for (int i = 0; i < 3; i++) begin
      if (stb[i]) begin
        if (q[i].size() == 0) chk({nm[i], "_unexpected"}, 64'd1, 64'd0);
        else begin
          e = q[i].pop_front();
          chk({nm[i], "_cycle"}, 64'(cyc), 64'(e.t));
          chk({nm[i], "_vars"}, vv[i], e.v);
        end
      end else begin
        chk({nm[i], "_vars_idle"}, vv[i], 64'd0);
      end
    end
    chk("out_ren_eq", {63'd0, out_ren}, {63'd0, pool_wen});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int st_off, input int st_len, input int cut_off);
    start = 1'b1;
    s0 = cyc;
    push_frame(s0, (st_off >= BIG) ? BIG : s0 + st_off, st_len,
               (cut_off >= BIG) ? BIG : s0 + cut_off);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_done));
    chk("sb_empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; stall = 1'b0;
    tick(); tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_strobes", {61'd0, in_wen, pool_ren, pool_wen}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Plain frame, with a start pulse during RUN that must be ignored.
    start_frame(BIG, 0, BIG);
    while (cyc < s0 + 5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", {63'd0, busy}, 64'd1);
    wait_done(200);

    // Back-to-back: start in the done cycle.
    start_frame(BIG, 0, BIG);
    wait_done(200);

    // Five-cycle stall in the middle of a row.
    start_frame(10, 5, BIG);
    while (cyc < s0 + 10) tick();
    stall = 1'b1;
    while (cyc < s0 + 15) tick();
    stall = 1'b0;
    wait_done(200);

    // Flush mid-frame: strobes stop after the flush cycle.
    start_frame(BIG, 0, 12);
    while (cyc < s0 + 12) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_wen", {63'd0, in_wen}, 64'd0);
    repeat (6) tick();
    chk("flush_sb_empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);

    // Restart after flush reproduces a full frame.
    start_frame(BIG, 0, BIG);
    wait_done(200);

    // start and flush together: flush wins, block returns to IDLE.
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    tick();
    chk("sf_busy", {63'd0, busy}, 64'd0);
    chk("sf_done", {63'd0, done}, 64'd0);

    // Asynchronous reset mid-frame.
    start_frame(BIG, 0, 7);
    while (cyc < s0 + 8) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {61'd0, in_wen, pool_ren, pool_wen}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_vars", pk(in_cv), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("arst_sb_empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    chk("arst_idle", {62'd0, busy, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
